// File: rtl/memory_a_pkg.sv
// memory_a_pkg: shared widths, lane positions and pixel type for the memory_a frame buffer.
package memory_a_pkg;
    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 32;
    localparam int PIX_W     = 24;
    localparam int LANE_W    = 8;
    localparam int LANE0_LSB = 0;
    localparam int LANE1_LSB = 8;
    localparam int LANE2_LSB = 16;
    typedef logic [23:0] pixel_t;
endpackage

// File: rtl/memory_a_ram.sv
// memory_a_ram: pixel storage array with a write port and an enabled, resettable registered read.
module memory_a_ram
    import memory_a_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int PW = PIX_W
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [PW-1:0] wd_i,
    output logic [PW-1:0] rd_o
);
    logic [PW-1:0] mem_q [2**AW] = '{default: '0};
    logic [PW-1:0] rd_q;

    // A read coinciding with a write returns the incoming data (write-first).
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_q <= '0;
        end else begin
            if (we_i) mem_q[addr_i] <= wd_i;
            if (re_i) rd_q <= we_i ? wd_i : mem_q[addr_i];
        end
    end

    assign rd_o = rd_q;
endmodule

// File: rtl/memory_a.sv
// memory_a: single-port 24-bit pixel frame buffer with byte-lane outputs.
// Define MEMA_WR_BYPASS_EN to make a simultaneous write+read load the write data into dataout.
module memory_a #(
    parameter int ADDR_W = memory_a_pkg::ADDR_W,
    parameter int DATA_W = memory_a_pkg::DATA_W,
    parameter int PIX_W  = memory_a_pkg::PIX_W
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [PIX_W-1:0]  dataout,
    output logic [7:0]        dataout00,
    output logic [7:0]        dataout01,
    output logic [7:0]        dataout02,
    input  logic [DATA_W-1:0] WData,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              WE0,
    input  logic              RE0
);
    import memory_a_pkg::*;

    logic rd_en;
    logic unused_wdata_hi;

`ifdef MEMA_WR_BYPASS_EN
    assign rd_en = RE0;
`else
    assign rd_en = RE0 & ~WE0;
`endif

    assign unused_wdata_hi = ^WData[DATA_W-1:PIX_W];

    memory_a_ram #(.AW(ADDR_W), .PW(PIX_W)) u_ram (
        .clk_i  (clock),
        .rst_n_i(reset_n),
        .we_i   (WE0),
        .re_i   (rd_en),
        .addr_i (addr0),
        .wd_i   (WData[PIX_W-1:0]),
        .rd_o   (dataout)
    );

    assign dataout00 = dataout[LANE0_LSB +: LANE_W];
    assign dataout01 = dataout[LANE1_LSB +: LANE_W];
    assign dataout02 = dataout[LANE2_LSB +: LANE_W];
endmodule

// File: tb/tb_memory_a.sv
// tb_memory_a: directed vector table plus randomized traffic checked against a behavioural model.
module tb_memory_a;
    import memory_a_pkg::*;

`ifdef MEMA_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n;
    logic [PIX_W-1:0]  dataout;
    logic [7:0]        dataout00, dataout01, dataout02;
    logic [DATA_W-1:0] WData;
    logic [ADDR_W-1:0] addr0;
    logic              WE0, RE0;

    memory_a dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .dataout  (dataout),
        .dataout00(dataout00),
        .dataout01(dataout01),
        .dataout02(dataout02),
        .WData    (WData),
        .addr0    (addr0),
        .WE0      (WE0),
        .RE0      (RE0)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit                rn;
        bit                we;
        bit                re;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        pixel_t            exp;
    } vec_t;

    pixel_t model_mem [int];
    pixel_t model_dout = '0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit we, input bit re,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        reset_n = rn; WE0 = we; RE0 = re; addr0 = a; WData = wd;
        @(posedge clock);
        #1;
        if (!rn) begin
            model_dout = '0;
        end else begin
            if (re && (!we || BYP))
                model_dout = we ? wd[23:0] : (model_mem.exists(int'(a)) ? model_mem[int'(a)] : 24'h0);
            if (we) model_mem[int'(a)] = wd[23:0];
        end
        chk("dout_model", dataout, model_dout);
        chk("lane0", {16'h0, dataout00}, {16'h0, model_dout[7:0]});
        chk("lane1", {16'h0, dataout01}, {16'h0, model_dout[15:8]});
        chk("lane2", {16'h0, dataout02}, {16'h0, model_dout[23:16]});
    endtask

    initial begin
        vec_t tbl [$];
        tbl.push_back('{0, 0, 0, 20'h0,     32'h0,        24'h000000});
        tbl.push_back('{0, 0, 1, 20'h0,     32'h0,        24'h000000});
        tbl.push_back('{1, 1, 0, 20'h0,     32'h000000AA, 24'h000000});
        tbl.push_back('{1, 1, 0, 20'h1,     32'h000000AF, 24'h000000});
        tbl.push_back('{1, 0, 1, 20'h0,     32'h0,        24'h0000AA});
        tbl.push_back('{1, 0, 1, 20'h1,     32'h0,        24'h0000AF});
        tbl.push_back('{1, 1, 0, 20'h5,     32'hFF123456, 24'h0000AF});
        tbl.push_back('{1, 0, 1, 20'h5,     32'h0,        24'h123456});
        tbl.push_back('{1, 0, 0, 20'h9,     32'hDEADBEEF, 24'h123456});
        tbl.push_back('{1, 0, 0, 20'h3,     32'h0,        24'h123456});
        tbl.push_back('{1, 0, 0, 20'h5,     32'h0,        24'h123456});
        tbl.push_back('{1, 1, 0, 20'h7,     32'h00111111, 24'h123456});
        tbl.push_back('{1, 1, 0, 20'h8,     32'h00222222, 24'h123456});
        tbl.push_back('{1, 0, 1, 20'h8,     32'h0,        24'h222222});
        tbl.push_back('{1, 1, 1, 20'h7,     32'h00333333, BYP ? 24'h333333 : 24'h222222});
        tbl.push_back('{1, 0, 1, 20'h7,     32'h0,        24'h333333});
        tbl.push_back('{1, 1, 0, 20'h2,     32'h00ABCDEF, 24'h333333});
        tbl.push_back('{0, 0, 1, 20'h2,     32'h0,        24'h000000});
        tbl.push_back('{1, 0, 1, 20'h2,     32'h0,        24'hABCDEF});
        tbl.push_back('{0, 1, 1, 20'h3,     32'h00555555, 24'h000000});
        tbl.push_back('{1, 0, 1, 20'h3,     32'h0,        24'h000000});
        tbl.push_back('{1, 0, 1, 20'hFFFFF, 32'h0,        24'h000000});
        tbl.push_back('{1, 1, 0, 20'hFFFFF, 32'h77C0FFEE, 24'h000000});
        tbl.push_back('{1, 0, 1, 20'hFFFFF, 32'h0,        24'hC0FFEE});
        tbl.push_back('{1, 0, 1, 20'h1,     32'h0,        24'h0000AF});
        tbl.push_back('{1, 0, 1, 20'h0,     32'h0,        24'h0000AA});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rn, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd);
            chk($sformatf("vec%0d", i), dataout, tbl[i].exp);
        end

        for (int i = 0; i < 600; i++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
            step($urandom_range(0, 31) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
